// File: rtl/shift_add_mul.sv
// Sequential shift-and-add multiplier computing x = q*y + r.
// One multiplier bit is retired per cycle; results are exact in 2*WIDTH bits.
module shift_add_mul #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     y,
    input  logic [WIDTH-1:0]     q,
    input  logic [WIDTH-1:0]     r,
    output logic [2*WIDTH-1:0]   x,
    output logic                 busy,
    output logic                 done
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CALC    = 2'd1;
    localparam logic [1:0] DONE_ST = 2'd2;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   ycap;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH:0]     sum;

    // One step: conditionally add y to the upper half, keep the carry,
    // then shift {carry, upper, lower} right by one.
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]}
                + (acc[0] ? {1'b0, ycap} : '0);
        acc_nxt = {sum, acc[WIDTH-1:1]};
    end

    // Control FSM, operand capture, accumulator and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            ycap  <= '0;
            acc   <= '0;
            x     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        ycap  <= y;
                        acc   <= {r, q};
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        x     <= acc_nxt;
                        state <= DONE_ST;
                    end
                end
                DONE_ST: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE_ST);

endmodule
